// File: rtl/spi_sram_target.sv
// SPI serial-SRAM target: decodes READ(0x03)/WRITE(0x02) + 24-bit address, streams bytes to/from an internal array.
// Latency: read bit 7 of mem[A] is registered onto miso at edge 33+DUMMY; write bytes land on the 8th bit edge of each byte.
// Backpressure: none; the master owns the link via cs_n, and any high sample aborts to IDLE, dropping partial bytes.
module spi_sram_target #(
    parameter int ADDR_BITS = 16,
    parameter int DUMMY     = 0
) (
    input  logic clk,
    input  logic arst_n,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic busy
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] LP_DUMMY = 4'(DUMMY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [4:0]  r_cnt;        // bit counter within the command / address / write-byte phase
    logic [7:0]  r_shift;      // command and write-data shifter
    logic [23:0] r_addr;       // byte address counter; low ADDR_BITS index the array
    logic        r_is_rd;      // command latched at edge 8 was READ
    logic [7:0]  r_rd_shift;   // prefetched read byte, shifted out MSB first
    logic [2:0]  r_bit;        // bit position of the byte currently on miso
    logic [3:0]  r_dly;        // turnaround cycles elapsed before the first read bit
    logic        r_miso;
    logic        r_busy;

    logic [7:0]  r_mem [DEPTH];

    logic [7:0]           w_byte_in;
    logic [23:0]          w_addr_full;
    logic                 w_cmd_last;
    logic                 w_addr_last;
    logic                 w_we;
    logic [ADDR_BITS-1:0] w_rd_idx;

    assign w_byte_in   = {r_shift[6:0], mosi};
    assign w_addr_full = {r_addr[22:0], mosi};
    assign w_cmd_last  = (r_state == S_CMD)  && (r_cnt == 5'd7);
    assign w_addr_last = (r_state == S_ADDR) && (r_cnt == 5'd23);
    // A high cs_n sample is never a bit edge, so a byte completing on it is not written.
    assign w_we        = !cs_n && (r_state == S_WDATA) && (r_cnt == 5'd7);
    // The first read byte is fetched straight from the address being completed on edge 32.
    assign w_rd_idx    = (r_state == S_ADDR) ? w_addr_full[ADDR_BITS-1:0] : r_addr[ADDR_BITS-1:0];

    assign miso = r_miso;
    assign busy = r_busy;

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a high cs_n sample returns to IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        if (cs_n) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_CMD;
                S_CMD: begin
                    if (w_cmd_last) begin
                        if ((w_byte_in == 8'h02) || (w_byte_in == 8'h03)) begin
                            w_state_nxt = S_ADDR;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_addr_last) begin
                        w_state_nxt = r_is_rd ? S_RDATA : S_WDATA;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Shifters, counters, read pipeline and the registered miso/busy outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_is_rd    <= 1'b0;
            r_rd_shift <= '0;
            r_bit      <= '0;
            r_dly      <= '0;
            r_miso     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_miso <= 1'b0;
            if (cs_n) begin
                r_cnt <= '0;
                r_bit <= '0;
                r_dly <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_shift <= w_byte_in;
                        r_cnt   <= 5'd1;
                    end
                    S_CMD: begin
                        r_shift <= w_byte_in;
                        r_cnt   <= w_cmd_last ? 5'd0 : r_cnt + 5'd1;
                        if (w_cmd_last) begin
                            r_is_rd <= (w_byte_in == 8'h03);
                        end
                    end
                    S_ADDR: begin
                        r_cnt  <= w_addr_last ? 5'd0 : r_cnt + 5'd1;
                        r_addr <= w_addr_full;
                        if (w_addr_last && r_is_rd) begin
                            r_rd_shift <= r_mem[w_rd_idx];
                            r_addr     <= w_addr_full + 24'd1;
                        end
                    end
                    S_WDATA: begin
                        r_shift <= w_byte_in;
                        if (r_cnt == 5'd7) begin
                            r_cnt  <= 5'd0;
                            r_addr <= r_addr + 24'd1;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    S_RDATA: begin
                        if (r_dly != LP_DUMMY) begin
                            r_dly <= r_dly + 4'd1;
                        end else begin
                            r_miso <= r_rd_shift[7];
                            r_bit  <= r_bit + 3'd1;
                            // While bit 0 goes out, the next byte is fetched so it follows with no gap.
                            if (r_bit == 3'd7) begin
                                r_rd_shift <= r_mem[w_rd_idx];
                                r_addr     <= r_addr + 24'd1;
                            end else begin
                                r_rd_shift <= {r_rd_shift[6:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Byte array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_addr[ADDR_BITS-1:0]] <= w_byte_in;
        end
    end

endmodule

// File: tb/tb_spi_sram_target.sv
// Bench for spi_sram_target: two instances (DUMMY=0 and DUMMY=4) share one SPI stimulus stream.
// Expected read data comes from a sparse byte-array model updated on every completed write byte.
// Only bytes the bench has written are compared; untouched memory is undefined.
module tb_spi_sram_target;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    logic cs_n   = 1'b1;
    logic mosi   = 1'b0;
    logic miso0, miso4, busy0, busy4;

    int errors = 0;
    int checks = 0;

    logic       mosi_q[$];
    logic       s0_q[$];
    logic       s4_q[$];
    logic       b0_q[$];
    logic [7:0] wr_q[$];
    logic       end_busy0, end_busy4;
    logic [7:0] mdl[int];

    always #5 clk = ~clk;

    spi_sram_target #(.ADDR_BITS(16), .DUMMY(0)) dut0 (
        .clk(clk), .arst_n(arst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso0), .busy(busy0)
    );

    spi_sram_target #(.ADDR_BITS(16), .DUMMY(4)) dut4 (
        .clk(clk), .arst_n(arst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso4), .busy(busy4)
    );

    // One clock: drive inputs, take the rising edge, settle 1 time unit.
    task automatic tick(input logic c, input logic b);
        cs_n = c;
        mosi = b;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) mosi_q.push_back(v[i]);
    endtask

    task automatic push_hdr(input logic [7:0] cmd, input logic [23:0] a);
        push_byte(cmd);
        push_byte(a[23:16]);
        push_byte(a[15:8]);
        push_byte(a[7:0]);
    endtask

    // Runs n low-cs edges (queued bits, then random filler); sample k-1 is miso after edge k.
    task automatic run_txn(input int n, input bit close);
        logic b;
        s0_q.delete();
        s4_q.delete();
        b0_q.delete();
        for (int k = 0; k < n; k++) begin
            if (k < mosi_q.size()) b = mosi_q[k];
            else b = 1'($urandom);
            tick(1'b0, b);
            s0_q.push_back(miso0);
            s4_q.push_back(miso4);
            b0_q.push_back(busy0);
        end
        mosi_q.delete();
        if (close) begin
            tick(1'b1, 1'b0);
            end_busy0 = busy0;
            end_busy4 = busy4;
        end
    endtask

    // Write wr_q at address a plus 'extra' stray bits; completed bytes enter the model.
    task automatic do_write(input logic [23:0] a, input int extra, input bit close);
        int nb;
        nb = wr_q.size();
        push_hdr(8'h02, a);
        foreach (wr_q[i]) push_byte(wr_q[i]);
        for (int i = 0; i < extra; i++) mosi_q.push_back(1'($urandom));
        run_txn(32 + 8 * nb + extra, close);
        for (int n = 0; n < nb; n++) mdl[(int'(a) + n) & 32'hFFFF] = wr_q[n];
        wr_q.delete();
    endtask

    // Enough edges for the slower (DUMMY=4) instance to deliver n bytes.
    task automatic do_read(input logic [23:0] a, input int n);
        push_hdr(8'h03, a);
        run_txn(36 + 8 * n, 1'b1);
    endtask

    function automatic int lat(input int d);
        lat = (d != 0) ? 4 : 0;
    endfunction

    // Byte n as seen by the master: bit 7 is sampled at edge 34+DUMMY, i.e. sample index 32+DUMMY.
    function automatic logic [7:0] got_byte(input int d, input int n);
        logic [7:0] v;
        int base;
        base = 32 + lat(d) + 8 * n;
        for (int j = 0; j < 8; j++) v[7-j] = (d != 0) ? s4_q[base+j] : s0_q[base+j];
        got_byte = v;
    endfunction

    function automatic bit lead_zero(input int d);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < 32 + lat(d); k++) begin
            if (((d != 0) ? s4_q[k] : s0_q[k]) !== 1'b0) ok = 1'b0;
        end
        lead_zero = ok;
    endfunction

    task automatic test_reset();
        arst_n = 1'b0;
        cs_n   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL reset_miso0: got %b want 0", miso0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0); end
        checks++; if (miso4 !== 1'b0) begin errors++; $display("FAIL reset_miso4: got %b want 0", miso4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b want 0", busy4); end
        arst_n = 1'b1;
        tick(1'b1, 1'b0);
    endtask

    task automatic test_write_read();
        logic [7:0] exp_b[4];
        exp_b = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) wr_q.push_back(exp_b[i]);
        do_write(24'h000010, 0, 1'b1);
        checks++; if (b0_q[0] !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", b0_q[0]); end
        checks++; if (end_busy0 !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", end_busy0); end
        do_read(24'h000010, 4);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (!lead_zero(d)) begin errors++; $display("FAIL wr_rd_lead dut%0d: miso not 0 before data", lat(d)); end
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (got_byte(d, n) !== exp_b[n]) begin
                    errors++; $display("FAIL wr_rd_byte%0d dut%0d: got %h want %h", n, lat(d), got_byte(d, n), exp_b[n]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        wr_q.push_back(8'h11);
        wr_q.push_back(8'h22);
        do_write(24'h00FFFF, 0, 1'b1);
        do_read(24'h00FFFF, 2);
        for (int d = 0; d < 2; d++) begin
            checks++; if (got_byte(d, 0) !== 8'h11) begin errors++; $display("FAIL wrap_b0 dut%0d: got %h want 11", lat(d), got_byte(d, 0)); end
            checks++; if (got_byte(d, 1) !== 8'h22) begin errors++; $display("FAIL wrap_b1 dut%0d: got %h want 22", lat(d), got_byte(d, 1)); end
        end
        do_read(24'h000000, 1);
        for (int d = 0; d < 2; d++) begin
            checks++; if (got_byte(d, 0) !== 8'h22) begin errors++; $display("FAIL wrap_zero dut%0d: got %h want 22", lat(d), got_byte(d, 0)); end
        end
    endtask

    task automatic test_ignore();
        bit z0, z4;
        push_hdr(8'h9F, 24'h000010);
        for (int i = 0; i < 16; i++) mosi_q.push_back(1'($urandom));
        run_txn(48, 1'b1);
        z0 = 1'b1;
        z4 = 1'b1;
        foreach (s0_q[k]) if (s0_q[k] !== 1'b0) z0 = 1'b0;
        foreach (s4_q[k]) if (s4_q[k] !== 1'b0) z4 = 1'b0;
        checks++; if (!z0) begin errors++; $display("FAIL ignore_miso dut0: miso went nonzero, want constant 0"); end
        checks++; if (!z4) begin errors++; $display("FAIL ignore_miso dut4: miso went nonzero, want constant 0"); end
        do_read(24'h000010, 4);
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (got_byte(d, n) !== mdl[16 + n]) begin
                    errors++; $display("FAIL ignore_keep%0d dut%0d: got %h want %h", n, lat(d), got_byte(d, n), mdl[16 + n]);
                end
            end
        end
    endtask

    task automatic test_partial();
        wr_q.push_back(8'h5E);
        wr_q.push_back(8'h6F);
        wr_q.push_back(8'h81);
        do_write(24'h000020, 0, 1'b1);
        wr_q.push_back(8'h77);
        do_write(24'h000020, 5, 1'b1);
        // cs_n rises exactly where the byte at 0x22 would have completed.
        do_write(24'h000022, 7, 1'b1);
        do_read(24'h000020, 3);
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 3; n++) begin
                checks++;
                if (got_byte(d, n) !== mdl[32 + n]) begin
                    errors++; $display("FAIL partial_b%0d dut%0d: got %h want %h", n, lat(d), got_byte(d, n), mdl[32 + n]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        push_hdr(8'h03, 24'h000010);
        run_txn(44, 1'b0);
        arst_n = 1'b0;
        #1;
        checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL rstmid_miso0: got %b want 0", miso0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy0: got %b want 0", busy0); end
        checks++; if (miso4 !== 1'b0) begin errors++; $display("FAIL rstmid_miso4: got %b want 0", miso4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rstmid_busy4: got %b want 0", busy4); end
        #2 arst_n = 1'b1;
        tick(1'b1, 1'b0);
        wr_q.push_back(8'hC3);
        wr_q.push_back(8'h3C);
        do_write(24'h000030, 0, 1'b1);
        wr_q.push_back(8'h5A);
        do_write(24'h000030, 4, 1'b0);
        arst_n = 1'b0;
        #2 arst_n = 1'b1;
        tick(1'b1, 1'b0);
        do_read(24'h000010, 2);
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 2; n++) begin
                checks++;
                if (got_byte(d, n) !== mdl[16 + n]) begin
                    errors++; $display("FAIL rstmid_rd%0d dut%0d: got %h want %h", n, lat(d), got_byte(d, n), mdl[16 + n]);
                end
            end
        end
        do_read(24'h000030, 2);
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 2; n++) begin
                checks++;
                if (got_byte(d, n) !== mdl[48 + n]) begin
                    errors++; $display("FAIL rstmid_wr%0d dut%0d: got %h want %h", n, lat(d), got_byte(d, n), mdl[48 + n]);
                end
            end
        end
    endtask

    // Random writes, then back-to-back reads with one cs_n-high cycle between them.
    task automatic test_back_to_back();
        logic [23:0] a, ra;
        int len, off, rl, idx;
        for (int r = 0; r < 4; r++) begin
            a   = 24'($urandom);
            if (r[0]) a[15:0] = 16'hFFFC;
            len = $urandom_range(8, 4);
            for (int i = 0; i < len; i++) wr_q.push_back(8'($urandom));
            do_write(a, 0, 1'b1);
            for (int t = 0; t < 3; t++) begin
                off = $urandom_range(len - 1, 0);
                rl  = $urandom_range(len - off, 1);
                ra  = a + 24'(off);
                do_read(ra, rl);
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (!lead_zero(d)) begin errors++; $display("FAIL b2b_lead r%0d dut%0d: miso not 0 before data", r, lat(d)); end
                    for (int n = 0; n < rl; n++) begin
                        idx = (int'(ra) + n) & 32'hFFFF;
                        checks++;
                        if (got_byte(d, n) !== mdl[idx]) begin
                            errors++; $display("FAIL b2b_byte addr %h dut%0d: got %h want %h", idx, lat(d), got_byte(d, n), mdl[idx]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_ignore();
        test_partial();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/spi_sram_target.md
# spi_sram_target

Synthesizable SPI serial-SRAM target: the responder end of the byte-serial SRAM link that `spi_sram_master` initiates. It decodes 8-bit READ/WRITE commands and a 24-bit address from `mosi` and streams sequential bytes to and from an internal byte array on `miso`. It is used as the on-chip/FPGA stand-in for the external SRAM in SoC builds and simulation, so it runs on the same `clk` that clocks the SPI link.

## Interface
- `ADDR_BITS`, default 16: memory depth is 2^ADDR_BITS bytes; the low ADDR_BITS of the 24-bit received address are used.
- `DUMMY`, default 0: extra turnaround cycles between the last address bit and the first read data bit (0–15).
- `clk`  in  1: single clock; serial bit clock is `clk` itself.
- `arst_n`  in  1: asynchronous active-low reset.
- `cs_n`  in  1: chip select, active low; sampled on rising `clk`.
- `mosi`  in  1: serial data in, MSB first, sampled on rising `clk` while `cs_n` is low.
- `miso`  out  1: serial read data, registered; driven 0 whenever no read data bit is valid.
- `busy`  out  1: high while a transaction is in progress (state ≠ IDLE); registered.

## Operation
- Edge numbering: edge k is the k-th rising `clk` of a transaction at which `cs_n` is sampled low. A transaction starts at the first low sample after reset or after `cs_n` was sampled high.
- Edges 1–8 shift the command byte. Edges 9–32 shift address bits 23..0.
- States: IDLE → CMD → ADDR → {WDATA | RDATA | IGNORE}. Any edge with `cs_n` sampled high forces IDLE, from any state.
- Command decode at edge 8: 0x02 → WRITE, 0x03 → READ, anything else → IGNORE. IGNORE never writes memory, and `miso` stays 0 until `cs_n` goes high.
- WRITE (WDATA): from edge 33, each group of 8 edges shifts one byte, MSB first. On the 8th bit edge of byte n, `mem[A+n]` is written and the address increments. A partial byte when `cs_n` rises is discarded.
- READ (RDATA): bit 7 of `mem[A]` appears on `miso` after edge 33+DUMMY. One bit follows per cycle, and byte n+1 follows byte n with no gap.
  - The next byte is fetched from the array no later than the edge that presents bit 0 of the current byte.
  - Reading continues indefinitely while `cs_n` stays low.
- Address arithmetic: a 24-bit counter increments per byte. The array index is the counter modulo 2^ADDR_BITS, so address 2^ADDR_BITS−1 is followed by 0.
- Memory contents are not cleared by reset and are undefined after configuration.

## Timing
- Reset: state IDLE, `miso`=0, `busy`=0, all shift registers and counters 0. Reset mid-transaction aborts with no write of a partial byte; completed byte writes are kept.
- `busy` rises the cycle after edge 1 and falls the cycle after the first edge that samples `cs_n` high.
- Read latency: the master samples data bit 7 at edge 34+DUMMY. `miso` is 0 during edges 1..33+DUMMY.
- Write latency: the byte is visible to a read transaction started any later cycle.
- Minimum `cs_n` high time between transactions: 1 cycle. A new command's edge 1 may be the very next low sample.
- `cs_n` rising during the address phase: no memory access.
- `cs_n` rising on the same cycle a byte would complete: that edge is not a bit edge, so the byte is discarded.

## Test plan
- WRITE 0x02, addr 0x000010, data A5 3C 00 FF, then READ 0x03 from 0x000010 for 4 bytes -> `miso` returns A5 3C 00 FF, first bit sampled at edge 34, no inter-byte gap.
- ADDR_BITS=16: write 0x11 0x22 starting at 0x00FFFF, then read 2 bytes from 0x00FFFF -> 11 22; read 1 byte from 0x000000 -> 22.
- Command 0x9F followed by 40 `mosi` toggles -> `miso` constant 0, and a subsequent read of the touched range returns the previous contents.
- WRITE to 0x000020: byte 0x77 complete, then 5 bits of a second byte, then `cs_n` high -> 0x20 = 77, 0x21 unchanged.
- READ in progress, `arst_n` pulsed low mid-byte -> `miso`=0 and `busy`=0 immediately. A new READ after release returns the correct data.
- DUMMY=4: back-to-back READs separated by a 1-cycle `cs_n` high -> first data bit sampled at edge 38 in both transactions, correct bytes in each.
